// File: rtl/inst_seq_player.sv
// inst_seq_player: replays a stored program of calculator instructions into
// the core's inst_wd/inst_vld handshake, with back-pressure, a fixed
// inter-instruction gap, loop mode, single-step mode and abort.
module inst_seq_player #(
  parameter int INST_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              step_mode,
  input  logic              step,
  input  logic              abort,
  input  logic              inst_rdy,
  output logic [INST_W-1:0] inst_wd,
  output logic              inst_vld,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              wr_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WSTEP = 3'd1,
    FETCH = 3'd2,
    ISSUE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
  localparam logic [7:0]        GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t            state_reg;
  state_t            state_next;
  state_t            cont_state;

  logic [INST_W-1:0] mem [DEPTH];
  logic [INST_W-1:0] rd_data_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W:0]   len_reg;
  logic [7:0]        gap_cnt_reg;
  logic              wr_err_reg;

  logic              idle;
  logic              aborting;
  logic              at_last;
  logic              finish_run;
  logic [ADDR_W-1:0] last_addr;

  assign idle       = (state_reg == IDLE);
  assign aborting   = abort && !idle;
  // len_reg is 1..DEPTH while running; taking the low bits minus one maps
  // DEPTH onto the top address because the subtraction wraps.
  assign last_addr  = len_reg[ADDR_W-1:0] - PC_ONE;
  assign at_last    = (pc_reg == last_addr);
  assign finish_run = at_last && !loop_mode;

  // Where the sequencer goes after a non-final transfer (modes sampled live).
  always_comb begin
    cont_state = step_mode ? WSTEP : FETCH;
    if (GAP_CYCLES > 0) begin
      cont_state = GAP;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_next = DONE;
          end else if (step_mode) begin
            state_next = WSTEP;
          end else begin
            state_next = FETCH;
          end
        end
      end
      WSTEP: begin
        if (step) begin
          state_next = FETCH;
        end
      end
      FETCH: state_next = ISSUE;
      ISSUE: begin
        if (inst_rdy) begin
          state_next = finish_run ? DONE : cont_state;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = step_mode ? WSTEP : FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (aborting) begin
      state_next = IDLE;
    end
  end

  // Program counter, latched length, gap counter and sticky write-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= '0;
      len_reg     <= '0;
      gap_cnt_reg <= '0;
      wr_err_reg  <= 1'b0;
    end else begin
      if (idle && start) begin
        len_reg    <= (len > DEPTH_L) ? DEPTH_L : len;
        wr_err_reg <= 1'b0;
      end else if (wr_en && !idle) begin
        wr_err_reg <= 1'b1;
      end

      if (aborting) begin
        pc_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              pc_reg <= '0;
            end
          end
          ISSUE: begin
            if (inst_rdy && !finish_run) begin
              pc_reg <= at_last ? '0 : pc_reg + PC_ONE;
            end
          end
          DONE:    pc_reg <= '0;
          default: pc_reg <= pc_reg;
        endcase
      end

      if (state_reg == GAP) begin
        gap_cnt_reg <= gap_cnt_reg + 8'd1;
      end else begin
        gap_cnt_reg <= 8'd0;
      end
    end
  end

  // Program memory: writes only while idle, registered read during FETCH.
  always_ff @(posedge clk) begin
    if (wr_en && idle) begin
      mem[wr_addr] <= wr_data;
    end
    if (state_reg == FETCH) begin
      rd_data_reg <= mem[pc_reg];
    end
  end

  // Outputs decoded from the current state; the word is held stable through ISSUE.
  always_comb begin
    inst_vld = (state_reg == ISSUE);
    inst_wd  = (state_reg == ISSUE) ? rd_data_reg : '0;
    busy     = !idle;
    done     = (state_reg == DONE);
    pc       = pc_reg;
    wr_err   = wr_err_reg;
  end

endmodule
